xyz_driver: RTL and testbench
=============================

# xyz_driver

Command sequencer that sits directly upstream of `xyz` and drives its `signal_b[2:0]` and `signal_e3` inputs. It collects the resulting `signal_c`/`signal_f` outputs. Commands are queued in a small FIFO and applied one at a time. After a programmable settle time, both outputs are sampled and returned on a valid/ready response port. This gives the test and control logic a handshaked, back-pressurable way to exercise `xyz`.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO entries; power of two, 2..16.
- `SETTLE`, 2: cycles between driving a command and sampling `signal_c`/`signal_f`; 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept; equals `!full`.
- `cmd_b`  in  3  value to drive on `signal_b`.
- `cmd_e3`  in  4  value to drive on `signal_e3`; only bit 0 reaches 1-bit `xyz.signal_e3`, and the full 4 bits are kept for wider hookups.
- `signal_b`  out  3  registered drive to `xyz`.
- `signal_e3`  out  4  registered drive to `xyz`.
- `signal_c`  in  1  from `xyz`.
- `signal_f`  in  1  from `xyz`.
- `rsp_valid`  out  1  response held.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_data`  out  2  {`signal_f`, `signal_c`} as sampled.
- `rsp_cnt`  out  8  completed responses, saturating at 255.
- `busy`  out  1  `state != IDLE || !empty`.

## Operation
- FIFO: `DEPTH`×7 bits {b,e3}, with read/write pointers and a `$clog2(DEPTH)+1` bit occupancy count.
  - Push on `cmd_valid && cmd_ready`.
  - Pop only from IDLE.
  - Push and pop in the same cycle are allowed when not empty; occupancy is unchanged.
  - No bypass: `cmd_ready` stays 0 when full, even if a pop happens that cycle.
  - Pointers wrap modulo `DEPTH`.
- FSM states: IDLE, SETTLE, RESP.
  - **IDLE**:
    - If FIFO non-empty: pop, load `signal_b`/`signal_e3` from the head entry, load `settle_cnt = SETTLE`, go to SETTLE.
    - Else stay in IDLE.
  - **SETTLE**:
    - Decrement `settle_cnt` each cycle.
    - On the edge where `settle_cnt == 1`: capture `rsp_data <= {signal_f, signal_c}`, set `rsp_valid`, go to RESP.
  - **RESP**:
    - Hold `rsp_data` and `rsp_valid` stable until `rsp_ready`.
    - On `rsp_valid && rsp_ready`: clear `rsp_valid`, increment `rsp_cnt` (saturating; stays 255), go to IDLE.
- Drive hold: `signal_b`/`signal_e3` keep the last command value between commands and change only on a pop.
- `cmd_e3` bits: only bit 0 is consumed by `xyz`, but all 4 bits are registered so the port matches `def.signal_e3[3:0]`.

## Timing
- Reset (`rst_n` low, asynchronous) clears:
  - state to IDLE, FIFO to empty, pointers to 0;
  - `signal_b = 0`, `signal_e3 = 0`, `rsp_valid = 0`, `rsp_data = 0`, `rsp_cnt = 0`;
  - `cmd_ready = 1`, `busy = 0`.
  - Release is synchronous to `clk`; the first push is possible on the first edge after deassertion.
- Reset mid-operation discards the FIFO contents and any pending response; it is not counted.
- Command pushed at edge P (FIFO empty, IDLE):
  - popped at edge P+1, so `signal_b` is valid after P+1;
  - sample edge is P+1+`SETTLE`, with `rsp_valid` high after it.
- `rsp_ready` held high:
  - response accepted on the next edge, P+2+`SETTLE`;
  - next pop at P+3+`SETTLE`;
  - throughput is 1 command per `SETTLE`+2 cycles.
- Pop and push are never blocked by a pending response beyond the FSM order: the FIFO keeps accepting while in SETTLE/RESP until full.
- `rsp_valid` never drops without a handshake. `rsp_data` never changes while `rsp_valid` is high.

## Test plan
- **Reset:** hold `rst_n` low with random inputs -> all outputs at their reset values, `cmd_ready = 1`, `busy = 0`.
- **Single command:** `SETTLE = 2`, push `b = 3'b101`, `e3 = 4'h9` at edge 0, with `signal_c = 1`, `signal_f = 0`:
  - `signal_b = 5` after edge 1;
  - `rsp_valid` after edge 3 with `rsp_data = 2'b01`;
  - `rsp_cnt = 1` after edge 4.
- **Fill to full:** `DEPTH = 4`, `rsp_ready = 0`, push 6 commands back-to-back:
  - first pop at edge 1, so 5 accepted;
  - `cmd_ready = 0` from then until the response handshake, with no loss;
  - responses come out in push order.
- **Backpressure:** hold `rsp_ready = 0` for 10 cycles while toggling `signal_c`/`signal_f` -> `rsp_data` stable, `signal_b` unchanged, no further pop.
- **Reset mid-SETTLE:** assert `rst_n` low with 2 commands queued -> FIFO empty, no response after release, `rsp_cnt = 0`.
- **Counter saturation:** complete 260 commands -> `rsp_cnt` stays at 255, with no wrap to 0.

Source files
------------

// File: rtl/xyz_driver.sv
// Queued command sequencer for xyz: drives signal_b/signal_e3 from a FIFO,
// waits a settle time, samples {signal_f, signal_c} and returns it via valid/ready.
module xyz_driver #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_b,
  input  logic [3:0] cmd_e3,
  output logic [2:0] signal_b,
  output logic [3:0] signal_e3,
  input  logic       signal_c,
  input  logic       signal_f,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_data,
  output logic [7:0] rsp_cnt,
  output logic       busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_RESP} state_t;

  state_t          state_reg, state_next;
  logic [3:0]      settle_cnt_reg, settle_cnt_next;
  logic [6:0]      fifo_mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [2:0]      signal_b_reg;
  logic [3:0]      signal_e3_reg;
  logic            rsp_valid_reg;
  logic [1:0]      rsp_data_reg;
  logic [7:0]      rsp_cnt_reg;

  logic full, empty, push, pop, capture, accept;
  logic [6:0] head;

  assign full      = (count_reg == CW'(DEPTH));
  assign empty     = (count_reg == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign head      = fifo_mem[rd_ptr_reg];

  assign signal_b  = signal_b_reg;
  assign signal_e3 = signal_e3_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_cnt   = rsp_cnt_reg;
  assign busy      = (state_reg != ST_IDLE) || !empty;

  // Storage carries no reset; occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {cmd_b, cmd_e3};
  end

  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    pop             = 1'b0;
    capture         = 1'b0;
    accept          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!empty) begin
          pop             = 1'b1;
          settle_cnt_next = 4'(SETTLE);
          state_next      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        settle_cnt_next = settle_cnt_reg - 4'd1;
        if (settle_cnt_reg == 4'd1) begin
          capture    = 1'b1;
          state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_valid_reg && rsp_ready) begin
          accept     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      settle_cnt_reg <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      signal_b_reg   <= '0;
      signal_e3_reg  <= '0;
      rsp_valid_reg  <= 1'b0;
      rsp_data_reg   <= '0;
      rsp_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      settle_cnt_reg <= settle_cnt_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop) begin
        rd_ptr_reg    <= rd_ptr_reg + AW'(1);
        signal_b_reg  <= head[6:4];
        signal_e3_reg <= head[3:0];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if (capture) begin
        rsp_data_reg  <= {signal_f, signal_c};
        rsp_valid_reg <= 1'b1;
      end else if (accept) begin
        rsp_valid_reg <= 1'b0;
      end
      // Count saturates so long soak runs never appear to restart from zero.
      if (accept && rsp_cnt_reg != 8'hFF) rsp_cnt_reg <= rsp_cnt_reg + 8'd1;
    end
  end
endmodule

// File: tb/tb_xyz_driver.sv
// Bench for xyz_driver: directed table and sequences plus randomized traffic
// checked every cycle against a queue-based transaction model.
module tb_xyz_driver;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       rst_n, cmd_valid, signal_c, signal_f, rsp_ready;
  logic [2:0] cmd_b;
  logic [3:0] cmd_e3;
  logic       cmd_ready, rsp_valid, busy;
  logic [2:0] signal_b;
  logic [3:0] signal_e3;
  logic [1:0] rsp_data;
  logic [7:0] rsp_cnt;

  xyz_driver #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_b(cmd_b), .cmd_e3(cmd_e3), .signal_b(signal_b), .signal_e3(signal_e3),
    .signal_c(signal_c), .signal_f(signal_f), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_cnt(rsp_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Transaction model: a command queue plus one command in service whose
  // sample edge is a timestamp, and a pending response awaiting handshake.
  typedef struct packed { logic [2:0] b; logic [3:0] e3; } cmd_t;
  cmd_t       q[$];
  bit         m_inflight, m_pending;
  int         m_sample_at, m_cnt, t, hs_total;
  logic [2:0] m_b;
  logic [3:0] m_e3;
  logic [1:0] m_data;
  logic [2:0] hs_b[$];

  typedef struct {
    logic v; logic [2:0] b; logic [3:0] e3; logic c, f, rr;
    logic [2:0] xb; logic [3:0] xe3; logic xvalid; logic [1:0] xdata;
    logic [7:0] xcnt; logic xbusy;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at edge %0d", name, act, exp, t);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_inflight = 0; m_pending = 0; m_sample_at = 0; m_cnt = 0;
    m_b = '0; m_e3 = '0; m_data = '0;
  endtask

  task automatic model_edge();
    bit   do_push;
    cmd_t h, nc;
    t++;
    if (!rst_n) begin
      model_clear();
      return;
    end
    do_push = cmd_valid && (q.size() < DEPTH);
    if (m_pending && rsp_ready) begin
      m_pending  = 0;
      m_inflight = 0;
      if (m_cnt < 255) m_cnt++;
    end else if (!m_inflight && q.size() > 0) begin
      h = q.pop_front();
      m_b = h.b; m_e3 = h.e3;
      m_inflight  = 1;
      m_sample_at = t + SETTLE;
    end else if (m_inflight && !m_pending && t == m_sample_at) begin
      m_data    = {signal_f, signal_c};
      m_pending = 1;
    end
    if (do_push) begin
      nc.b = cmd_b; nc.e3 = cmd_e3;
      q.push_back(nc);
    end
  endtask

  task automatic compare_model();
    check("m_cmd_ready", 32'(cmd_ready), 32'(q.size() < DEPTH));
    check("m_busy",      32'(busy),      32'(m_inflight || q.size() != 0));
    check("m_signal_b",  32'(signal_b),  32'(m_b));
    check("m_signal_e3", 32'(signal_e3), 32'(m_e3));
    check("m_rsp_valid", 32'(rsp_valid), 32'(m_pending));
    check("m_rsp_data",  32'(rsp_data),  32'(m_data));
    check("m_rsp_cnt",   32'(rsp_cnt),   32'(m_cnt));
  endtask

  task automatic step();
    bit         hs;
    logic [2:0] b_now;
    logic [1:0] d_now;
    hs = rsp_valid && rsp_ready && rst_n;
    b_now = signal_b; d_now = rsp_data;
    @(posedge clk);
    model_edge();
    if (hs) begin
      hs_b.push_back(b_now);
      $display("rsp %0d: b=%0d data=%b", hs_total, b_now, d_now);
      hs_total++;
    end
    #1;
    compare_model();
  endtask

  task automatic randomize_inputs();
    cmd_valid = 1'($urandom); cmd_b = 3'($urandom); cmd_e3 = 4'($urandom);
    signal_c = 1'($urandom); signal_f = 1'($urandom);
    rsp_ready = ($urandom_range(0, 9) < 6);
  endtask

  initial begin
    int k, start;
    logic [1:0] hold_d;
    logic [2:0] hold_b;

    tbl[0] = '{1'b1, 3'd5, 4'd9, 1'b1, 1'b0, 1'b1, 3'd0, 4'd0, 1'b0, 2'd0, 8'd0, 1'b1};
    tbl[1] = '{1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b1, 3'd5, 4'd9, 1'b0, 2'd0, 8'd0, 1'b1};
    tbl[2] = '{1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b1, 3'd5, 4'd9, 1'b0, 2'd0, 8'd0, 1'b1};
    tbl[3] = '{1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b1, 3'd5, 4'd9, 1'b1, 2'd1, 8'd0, 1'b1};
    tbl[4] = '{1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b1, 3'd5, 4'd9, 1'b0, 2'd1, 8'd1, 1'b0};
    tbl[5] = '{1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 1'b1, 3'd5, 4'd9, 1'b0, 2'd1, 8'd1, 1'b0};

    t = 0; hs_total = 0;
    model_clear();
    rst_n = 1'b0;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      step();
      check("rst_signal_b", 32'(signal_b), 0);
      check("rst_signal_e3", 32'(signal_e3), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_data", 32'(rsp_data), 0);
      check("rst_rsp_cnt", 32'(rsp_cnt), 0);
      check("rst_cmd_ready", 32'(cmd_ready), 1);
      check("rst_busy", 32'(busy), 0);
    end
    rst_n = 1'b1;

    // Single command, edge by edge
    for (int i = 0; i < 6; i++) begin
      cmd_valid = tbl[i].v; cmd_b = tbl[i].b; cmd_e3 = tbl[i].e3;
      signal_c = tbl[i].c; signal_f = tbl[i].f; rsp_ready = tbl[i].rr;
      step();
      check("tbl_signal_b", 32'(signal_b), 32'(tbl[i].xb));
      check("tbl_signal_e3", 32'(signal_e3), 32'(tbl[i].xe3));
      check("tbl_rsp_valid", 32'(rsp_valid), 32'(tbl[i].xvalid));
      check("tbl_rsp_data", 32'(rsp_data), 32'(tbl[i].xdata));
      check("tbl_rsp_cnt", 32'(rsp_cnt), 32'(tbl[i].xcnt));
      check("tbl_busy", 32'(busy), 32'(tbl[i].xbusy));
    end

    // Fill to full with responses blocked, then drain and check order
    hs_b.delete();
    rsp_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cmd_valid = 1'b1; cmd_b = 3'(i); cmd_e3 = 4'(i);
      signal_c = 1'($urandom); signal_f = 1'($urandom);
      check("fill_ready", 32'(cmd_ready), 1);
      step();
    end
    cmd_b = 3'd6; cmd_e3 = 4'd6;
    for (int i = 0; i < 4; i++) begin
      check("full_ready", 32'(cmd_ready), 0);
      step();
    end
    rsp_ready = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin step(); k++; end
    check("fill_unblock", 32'(cmd_ready), 1);
    step();
    cmd_valid = 1'b0;
    k = 0;
    while (hs_b.size() < 6 && k < 100) begin
      signal_c = 1'($urandom); signal_f = 1'($urandom);
      step(); k++;
    end
    check("fill_rsp_count", 32'(hs_b.size()), 6);
    for (int i = 0; i < 6 && i < hs_b.size(); i++)
      check("fill_order", 32'(hs_b[i]), 32'(i + 1));

    // Backpressure: response and drive must hold while inputs toggle
    rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_b = 3'd7; cmd_e3 = 4'd3;
    step();
    cmd_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 20) begin step(); k++; end
    check("bp_rsp_valid", 32'(rsp_valid), 1);
    hold_d = rsp_data; hold_b = signal_b;
    check("bp_signal_b", 32'(signal_b), 7);
    for (int i = 0; i < 10; i++) begin
      cmd_valid = (i == 0); cmd_b = 3'd2; cmd_e3 = 4'd1;
      signal_c = ~signal_c; signal_f = 1'($urandom);
      step();
      check("bp_hold_valid", 32'(rsp_valid), 1);
      check("bp_hold_data", 32'(rsp_data), 32'(hold_d));
      check("bp_hold_b", 32'(signal_b), 32'(hold_b));
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    k = 0;
    while (busy && k < 50) begin step(); k++; end
    check("bp_drain", 32'(busy), 0);

    // Reset during SETTLE with a second command queued
    cmd_valid = 1'b1; cmd_b = 3'd4; cmd_e3 = 4'd4;
    step();
    cmd_b = 3'd6;
    step();
    cmd_valid = 1'b0;
    check("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_async_busy", 32'(busy), 0);
    step(); step();
    rst_n = 1'b1;
    check("mid_cmd_ready", 32'(cmd_ready), 1);
    for (int i = 0; i < 10; i++) begin
      step();
      check("mid_no_rsp", 32'(rsp_valid), 0);
      check("mid_idle", 32'(busy), 0);
    end
    check("mid_rsp_cnt", 32'(rsp_cnt), 0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      randomize_inputs();
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;

    // Counter saturation over 260 completed commands
    cmd_valid = 1'b1; rsp_ready = 1'b1;
    start = hs_total; k = 0;
    while (hs_total - start < 260 && k < 3000) begin
      cmd_b = 3'($urandom); cmd_e3 = 4'($urandom);
      signal_c = 1'($urandom); signal_f = 1'($urandom);
      step(); k++;
    end
    check("sat_done", 32'(hs_total - start >= 260), 1);
    check("sat_cnt", 32'(rsp_cnt), 255);
    cmd_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
